pipe_stall_ctrl: RTL and testbench

Central hazard and flush controller for the 5-stage RISC-V core. It drives the `StallBus` code into every inter-stage register: the PC register, IF/ID, ID/EX, EX/MEM and MEM/WB. It resolves four conditions in fixed priority: memory-stage busy, branch misprediction flush, load-use hazard, and instruction-fetch busy. A small FSM sequences multi-cycle flushes, and two counters record stall and flush statistics.

---
 rtl/pipe_stall_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl
//   Central hazard and flush controller for a 5-stage RISC-V pipeline.
//   Produces a 2-bit code (Pass/Hold/Bubb) for every inter-stage register
//   from four conditions in fixed priority: memory busy, branch
//   misprediction flush, load-use hazard and instruction-fetch busy.
//   A RUN/FLUSH FSM stretches the IF/ID bubble over FLUSH_CYCLES cycles.
//
// Ports
//   clk             clock, rising edge
//   rst             asynchronous reset, active low
//   if_busy         fetch has not returned an instruction this cycle
//   mem_busy        MEM stage load/store not complete this cycle
//   branch_error    EX resolved a mispredicted branch/jump
//   id_rs1_request  ID reads rs1        id_rs1_addr  rs1 address
//   id_rs2_request  ID reads rs2        id_rs2_addr  rs2 address
//   ex_rd_load      EX instruction is a load
//   ex_rd_addr      EX destination register
//   stall_*         stage codes (combinational, zero latency)
//   flushing        registered: FSM is in FLUSH
//   stall_cycles    registered: cycles with any code other than Pass
//   flush_count     registered: accepted branch_error events
module pipe_stall_ctrl #(
   parameter int FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_busy,
   input  logic        mem_busy,
   input  logic        branch_error,
   input  logic        id_rs1_request,
   input  logic        id_rs2_request,
   input  logic [4:0]  id_rs1_addr,
   input  logic [4:0]  id_rs2_addr,
   input  logic        ex_rd_load,
   input  logic [4:0]  ex_rd_addr,
   output logic [1:0]  stall_pc,
   output logic [1:0]  stall_if_id,
   output logic [1:0]  stall_id_ex,
   output logic [1:0]  stall_ex_mem,
   output logic [1:0]  stall_mem_wb,
   output logic        flushing,
   output logic [31:0] stall_cycles,
   output logic [15:0] flush_count
);

   localparam logic [1:0] PASS = 2'b00;
   localparam logic [1:0] HOLD = 2'b01;
   localparam logic [1:0] BUBB = 2'b10;

   localparam logic [2:0] FCNT_LOAD = 3'(FLUSH_CYCLES - 1);

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  fcnt_q, fcnt_d;
   logic        flushing_q, flushing_d;
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [15:0] flush_count_q, flush_count_d;

   logic load_use;
   logic br_accept;
   logic any_stall;

   assign load_use = ex_rd_load & (ex_rd_addr != 5'd0) &
                     ((id_rs1_request & (id_rs1_addr == ex_rd_addr)) |
                      (id_rs2_request & (id_rs2_addr == ex_rd_addr)));

   // A mispredict seen while MEM is busy is not taken yet; EX is held and
   // will present it again once memory completes.
   assign br_accept = branch_error & ~mem_busy;

   // Stage code decode. Reset forces Bubb immediately, independent of the
   // clock, so an in-progress flush is aborted in the same cycle.
   always_comb begin
      stall_pc     = PASS;
      stall_if_id  = PASS;
      stall_id_ex  = PASS;
      stall_ex_mem = PASS;
      stall_mem_wb = PASS;
      if (!rst) begin
         stall_pc     = BUBB;
         stall_if_id  = BUBB;
         stall_id_ex  = BUBB;
         stall_ex_mem = BUBB;
         stall_mem_wb = BUBB;
      end else if (mem_busy) begin
         stall_pc     = HOLD;
         stall_if_id  = HOLD;
         stall_id_ex  = HOLD;
         stall_ex_mem = HOLD;
         stall_mem_wb = BUBB;
      end else if (branch_error) begin
         // PC passes so it loads the redirect target.
         stall_if_id  = BUBB;
         stall_id_ex  = BUBB;
      end else if (state_q == FLUSH) begin
         // load_use is ignored here: the ID content is being discarded.
         stall_pc     = if_busy ? HOLD : PASS;
         stall_if_id  = BUBB;
      end else if (load_use) begin
         stall_pc     = HOLD;
         stall_if_id  = HOLD;
         stall_id_ex  = BUBB;
      end else if (if_busy) begin
         stall_pc     = HOLD;
         stall_if_id  = BUBB;
      end
   end

   assign any_stall = (stall_pc != PASS) | (stall_if_id != PASS) |
                      (stall_id_ex != PASS) | (stall_ex_mem != PASS) |
                      (stall_mem_wb != PASS);

   // Next-state logic for the flush FSM and statistics counters.
   always_comb begin
      state_d        = state_q;
      fcnt_d         = fcnt_q;
      stall_cycles_d = stall_cycles_q;
      flush_count_d  = flush_count_q;

      if (br_accept) begin
         flush_count_d = flush_count_q + 16'd1;
         // With a single-cycle flush the error cycle alone covers it.
         if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            fcnt_d  = FCNT_LOAD;
         end
      end else if ((state_q == FLUSH) && !mem_busy) begin
         if (fcnt_q <= 3'd1) begin
            state_d = RUN;
            fcnt_d  = 3'd0;
         end else begin
            fcnt_d  = fcnt_q - 3'd1;
         end
      end

      if (any_stall) begin
         stall_cycles_d = stall_cycles_q + 32'd1;
      end

      flushing_d = (state_d == FLUSH);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= RUN;
         fcnt_q         <= 3'd0;
         flushing_q     <= 1'b0;
         stall_cycles_q <= 32'd0;
         flush_count_q  <= 16'd0;
      end else begin
         state_q        <= state_d;
         fcnt_q         <= fcnt_d;
         flushing_q     <= flushing_d;
         stall_cycles_q <= stall_cycles_d;
         flush_count_q  <= flush_count_d;
      end
   end

   assign flushing     = flushing_q;
   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
module tb_pipe_stall_ctrl;

   logic        clk;
   logic        rst;
   logic        if_busy, mem_busy, branch_error;
   logic        id_rs1_request, id_rs2_request;
   logic [4:0]  id_rs1_addr, id_rs2_addr;
   logic        ex_rd_load;
   logic [4:0]  ex_rd_addr;

   logic [1:0]  a_pc, a_ifid, a_idex, a_exmem, a_memwb;
   logic        a_flushing;
   logic [31:0] a_stall;
   logic [15:0] a_fcount;

   logic [1:0]  b_pc, b_ifid, b_idex, b_exmem, b_memwb;
   logic        b_flushing;
   logic [31:0] b_stall;
   logic [15:0] b_fcount;

   pipe_stall_ctrl #(.FLUSH_CYCLES(2)) dut2 (
      .clk(clk), .rst(rst), .if_busy(if_busy), .mem_busy(mem_busy),
      .branch_error(branch_error),
      .id_rs1_request(id_rs1_request), .id_rs2_request(id_rs2_request),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .ex_rd_load(ex_rd_load), .ex_rd_addr(ex_rd_addr),
      .stall_pc(a_pc), .stall_if_id(a_ifid), .stall_id_ex(a_idex),
      .stall_ex_mem(a_exmem), .stall_mem_wb(a_memwb),
      .flushing(a_flushing), .stall_cycles(a_stall), .flush_count(a_fcount)
   );

   pipe_stall_ctrl #(.FLUSH_CYCLES(3)) dut3 (
      .clk(clk), .rst(rst), .if_busy(if_busy), .mem_busy(mem_busy),
      .branch_error(branch_error),
      .id_rs1_request(id_rs1_request), .id_rs2_request(id_rs2_request),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .ex_rd_load(ex_rd_load), .ex_rd_addr(ex_rd_addr),
      .stall_pc(b_pc), .stall_if_id(b_ifid), .stall_id_ex(b_idex),
      .stall_ex_mem(b_exmem), .stall_mem_wb(b_memwb),
      .flushing(b_flushing), .stall_cycles(b_stall), .flush_count(b_fcount)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Expected codes packed {pc, if_id, id_ex, ex_mem, mem_wb}
   localparam logic [9:0] ALL_PASS = 10'b00_00_00_00_00;
   localparam logic [9:0] ALL_BUBB = 10'b10_10_10_10_10;
   localparam logic [9:0] MEM_ROW  = 10'b01_01_01_01_10;
   localparam logic [9:0] BR_ROW   = 10'b00_10_10_00_00;
   localparam logic [9:0] FL_ROW   = 10'b00_10_00_00_00;
   localparam logic [9:0] FL_IFB   = 10'b01_10_00_00_00;
   localparam logic [9:0] LU_ROW   = 10'b01_01_10_00_00;
   localparam logic [9:0] IFB_ROW  = 10'b01_10_00_00_00;

   typedef struct packed {
      logic [9:0] codes;
      logic       fl;
   } exp_t;

   exp_t        sb[$];
   int          tests = 0;
   int          fails = 0;
   int unsigned m_stall = 0;
   int unsigned m_acc = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // lu: 0 none, 1 rs2 match, 2 rs1 match, 3 match on x0, 4 address mismatch
   task automatic drive(input logic ib, input logic mb, input logic be, input int lu);
      if_busy        = ib;
      mem_busy       = mb;
      branch_error   = be;
      id_rs1_request = 1'b0;
      id_rs2_request = 1'b0;
      id_rs1_addr    = 5'd0;
      id_rs2_addr    = 5'd0;
      ex_rd_load     = 1'b0;
      ex_rd_addr     = 5'd0;
      case (lu)
         1: begin ex_rd_load = 1'b1; ex_rd_addr = 5'd5;
                  id_rs2_request = 1'b1; id_rs2_addr = 5'd5; end
         2: begin ex_rd_load = 1'b1; ex_rd_addr = 5'd17;
                  id_rs1_request = 1'b1; id_rs1_addr = 5'd17; end
         3: begin ex_rd_load = 1'b1; ex_rd_addr = 5'd0;
                  id_rs1_request = 1'b1; id_rs2_request = 1'b1; end
         4: begin ex_rd_load = 1'b1; ex_rd_addr = 5'd9;
                  id_rs1_request = 1'b1; id_rs1_addr = 5'd8;
                  id_rs2_request = 1'b1; id_rs2_addr = 5'd10; end
         default: ;
      endcase
   endtask

   // Called at posedge+1. sel=0 checks dut2 (FLUSH_CYCLES=2), sel=1 dut3.
   task automatic step(input string tag, input int sel,
                       input logic ib, input logic mb, input logic be, input int lu,
                       input logic [9:0] ecodes, input logic efl);
      exp_t       e;
      logic [9:0] obs;
      drive(ib, mb, be, lu);
      sb.push_back('{codes: ecodes, fl: efl});
      if (ecodes != ALL_PASS) m_stall++;
      if (be && !mb) m_acc++;
      #3;
      e   = sb.pop_front();
      obs = (sel == 0) ? {a_pc, a_ifid, a_idex, a_exmem, a_memwb}
                       : {b_pc, b_ifid, b_idex, b_exmem, b_memwb};
      chk({tag, "_codes"}, 32'(obs), 32'(e.codes));
      @(posedge clk);
      #1;
      if (sel == 0) begin
         chk({tag, "_flushing"}, 32'(a_flushing), 32'(e.fl));
         chk({tag, "_stall_cycles"}, a_stall, m_stall);
         chk({tag, "_flush_count"}, 32'(a_fcount), 32'(m_acc[15:0]));
      end else begin
         chk({tag, "_flushing3"}, 32'(b_flushing), 32'(e.fl));
         chk({tag, "_flush_count3"}, 32'(b_fcount), 32'(m_acc[15:0]));
      end
   endtask

   initial begin
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 0);

      // Reset held for three cycles
      repeat (3) @(posedge clk);
      #1;
      chk("rst_codes", 32'({a_pc, a_ifid, a_idex, a_exmem, a_memwb}), 32'(ALL_BUBB));
      chk("rst_flushing", 32'(a_flushing), 32'd0);
      chk("rst_stall", a_stall, 32'd0);
      chk("rst_fcount", 32'(a_fcount), 32'd0);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;

      step("idle", 0, 1'b0, 1'b0, 1'b0, 0, ALL_PASS, 1'b0);

      // Load-use hazard and its variants
      step("lu_rs2", 0, 1'b0, 1'b0, 1'b0, 1, LU_ROW, 1'b0);
      step("lu_after", 0, 1'b0, 1'b0, 1'b0, 0, ALL_PASS, 1'b0);
      step("lu_rs1", 0, 1'b0, 1'b0, 1'b0, 2, LU_ROW, 1'b0);
      step("lu_x0", 0, 1'b0, 1'b0, 1'b0, 3, ALL_PASS, 1'b0);
      step("lu_miss", 0, 1'b0, 1'b0, 1'b0, 4, ALL_PASS, 1'b0);
      step("if_busy", 0, 1'b1, 1'b0, 1'b0, 0, IFB_ROW, 1'b0);
      step("lu_over_ifb", 0, 1'b1, 1'b0, 1'b0, 1, LU_ROW, 1'b0);

      // Two-cycle flush; load_use ignored inside FLUSH
      step("fl_err", 0, 1'b0, 1'b0, 1'b1, 0, BR_ROW, 1'b1);
      step("fl_t1", 0, 1'b0, 1'b0, 1'b0, 1, FL_ROW, 1'b0);
      step("fl_t2", 0, 1'b0, 1'b0, 1'b0, 0, ALL_PASS, 1'b0);

      // Flush with fetch busy in the FLUSH cycle
      step("fli_err", 0, 1'b0, 1'b0, 1'b1, 0, BR_ROW, 1'b1);
      step("fli_t1", 0, 1'b1, 1'b0, 1'b0, 0, FL_IFB, 1'b0);
      step("fli_t2", 0, 1'b0, 1'b0, 1'b0, 0, ALL_PASS, 1'b0);

      // mem_busy freezes the flush window
      step("fm_err", 0, 1'b0, 1'b0, 1'b1, 0, BR_ROW, 1'b1);
      for (int i = 0; i < 3; i++)
         step("fm_mem", 0, 1'b0, 1'b1, 1'b0, 0, MEM_ROW, 1'b1);
      step("fm_t4", 0, 1'b0, 1'b0, 1'b0, 0, FL_ROW, 1'b0);
      step("fm_t5", 0, 1'b0, 1'b0, 1'b0, 0, ALL_PASS, 1'b0);

      // branch_error + mem_busy + load_use: memory row wins, one flush counted
      step("sim_c1", 0, 1'b0, 1'b1, 1'b1, 1, MEM_ROW, 1'b0);
      step("sim_c2", 0, 1'b0, 1'b1, 1'b1, 1, MEM_ROW, 1'b0);
      step("sim_c3", 0, 1'b0, 1'b0, 1'b1, 1, BR_ROW, 1'b1);
      step("sim_c4", 0, 1'b0, 1'b0, 1'b0, 1, FL_ROW, 1'b0);
      step("sim_c5", 0, 1'b0, 1'b0, 1'b0, 0, ALL_PASS, 1'b0);

      // Reset asserted mid-flush aborts it immediately
      step("rf_err", 0, 1'b0, 1'b0, 1'b1, 0, BR_ROW, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 0);
      rst = 1'b0;
      #1;
      chk("rf_codes", 32'({a_pc, a_ifid, a_idex, a_exmem, a_memwb}), 32'(ALL_BUBB));
      chk("rf_flushing", 32'(a_flushing), 32'd0);
      chk("rf_fcount", 32'(a_fcount), 32'd0);
      m_stall = 0;
      m_acc   = 0;
      @(posedge clk);
      #1 rst = 1'b1;
      step("rf_after", 0, 1'b0, 1'b0, 1'b0, 0, ALL_PASS, 1'b0);

      // Back-to-back branch_error with FLUSH_CYCLES=3
      step("bb_t0", 1, 1'b0, 1'b0, 1'b1, 0, BR_ROW, 1'b1);
      step("bb_t1", 1, 1'b0, 1'b0, 1'b1, 0, BR_ROW, 1'b1);
      step("bb_t2", 1, 1'b0, 1'b0, 1'b0, 0, FL_ROW, 1'b1);
      step("bb_t3", 1, 1'b0, 1'b0, 1'b0, 0, FL_ROW, 1'b0);
      step("bb_t4", 1, 1'b0, 1'b0, 1'b0, 0, ALL_PASS, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
